mmio_led_player: RTL and testbench

Memory-mapped output peripheral for the Sly-Man-Says datapath.
- The processor `sw`s colour codes to a data-memory address; the block queues them in a FIFO and plays each one on the four game LEDs with fixed on/gap timing.
- It is the write-side counterpart of the read-only random-number port: it sits beside `RAM` on the same `wren`/`address_dmem`/`data` bus and decodes its own two addresses.

---
 rtl/mmio_led_player.sv | 189 ++++++++++++++++++
 tb/tb_mmio_led_player.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_led_player.sv
// Memory-mapped LED colour player: queues 2-bit colour codes stored by the CPU and plays them with fixed on/gap timing.
// Optional square-wave tone output is enabled by defining LED_PLAYER_TONE_EN.
module mmio_led_player #(
  parameter logic [11:0] ADDR_BASE  = 12'd6,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000,
  parameter int unsigned TONE_BASE  = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_status,
  output logic [3:0]  led,
  output logic        busy
`ifdef LED_PLAYER_TONE_EN
  ,
  output logic        tone
`endif
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [11:0] ADDR_CMD  = ADDR_BASE + 12'd1;
  localparam logic [6:0]  DEPTH_CNT = 7'(FIFO_DEPTH);
  localparam logic [31:0] ON_LOAD   = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LOAD  = 32'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [1:0]  colour, colour_nxt;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [6:0]    count;
  logic          overflow;

  logic push_req, cmd_wr, abort, ovf_clr;
  logic empty, full, pop, push_ok;

  assign push_req = wren && (address_dmem == ADDR_BASE);
  assign cmd_wr   = wren && (address_dmem == ADDR_CMD);
  assign abort    = cmd_wr && data[0];
  assign ovf_clr  = cmd_wr && data[1];

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign pop   = (state == IDLE) && !empty && !abort;
  // A pop in the same cycle frees a slot, so a push onto a full queue still lands.
  assign push_ok = push_req && (!full || pop);

  logic unused_bits;
  assign unused_bits = &{1'b0, data[31:2]};

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= data[1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (abort) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + 7'(push_ok) - 7'(pop);
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef LED_PLAYER_TONE_EN
  logic [31:0] tone_cnt, tone_cnt_nxt;
  logic        tone_nxt;

  function automatic logic [31:0] tone_reload(input logic [1:0] c);
    return 32'(TONE_BASE) * (32'(c) + 32'd1) - 32'd1;
  endfunction
`else
  logic unused_tone_base;
  assign unused_tone_base = (TONE_BASE != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      colour <= '0;
`ifdef LED_PLAYER_TONE_EN
      tone_cnt <= '0;
      tone     <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      colour <= colour_nxt;
`ifdef LED_PLAYER_TONE_EN
      tone_cnt <= tone_cnt_nxt;
      tone     <= tone_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    colour_nxt = colour;
`ifdef LED_PLAYER_TONE_EN
    tone_cnt_nxt = tone_cnt;
    tone_nxt     = 1'b0;
`endif
    if (abort) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            colour_nxt = mem[rd_ptr];
            timer_nxt  = ON_LOAD;
            state_nxt  = ON;
`ifdef LED_PLAYER_TONE_EN
            tone_cnt_nxt = tone_reload(mem[rd_ptr]);
`endif
          end
        end
        ON: begin
          if (timer == '0) begin
            timer_nxt = OFF_LOAD;
            state_nxt = GAP;
          end else begin
            timer_nxt = timer - 32'd1;
`ifdef LED_PLAYER_TONE_EN
            // Tone only runs while lit; it is forced low on the ON->GAP edge.
            if (tone_cnt == '0) begin
              tone_nxt     = ~tone;
              tone_cnt_nxt = tone_reload(colour);
            end else begin
              tone_nxt     = tone;
              tone_cnt_nxt = tone_cnt - 32'd1;
            end
`endif
          end
        end
        GAP: begin
          if (timer == '0) begin
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - 32'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  assign led  = (state == ON) ? (4'b0001 << colour) : '0;
  assign busy = (state != IDLE) || !empty;

  assign q_status = (address_dmem == ADDR_CMD) ?
                    {21'b0, count, overflow, full, empty, busy} : '0;

endmodule

// File: tb/tb_mmio_led_player.sv
// Bench for mmio_led_player: vector table for single/back-to-back playback plus hand sequences for
// overflow, full-with-pop, abort/wrap, reset mid-gap and (with LED_PLAYER_TONE_EN) the tone output.
module tb_mmio_led_player;
  localparam int unsigned ON  = 3;
  localparam int unsigned OFF = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_status;
  logic [3:0]  led;
  logic        busy;
`ifdef LED_PLAYER_TONE_EN
  logic        tone;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] sb [$];
  bit         sb_skip = 1'b0;

  mmio_led_player #(
    .ADDR_BASE (12'd6),
    .FIFO_DEPTH(4),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .TONE_BASE (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_status    (q_status),
    .led         (led),
`ifdef LED_PLAYER_TONE_EN
    .tone        (tone),
`endif
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [11:0] a, input logic [31:0] d);
    wren = w;
    address_dmem = a;
    data = d;
    @(posedge clock);
    #1;
    wren = 1'b0;
    address_dmem = '0;
    data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'd0, 32'd0);
  endtask

  task automatic push(input logic [1:0] c);
    sb.push_back(c);
    cyc(1'b1, 12'd6, {30'h0, c});
  endtask

  task automatic push_drop(input logic [1:0] c);
    cyc(1'b1, 12'd6, {30'h0, c});
  endtask

  task automatic cmd(input logic [31:0] v);
    cyc(1'b1, 12'd7, v);
  endtask

  task automatic chk_status(input string name, input logic [31:0] exp);
    address_dmem = 12'd7;
    #1;
    check(name, q_status, exp);
    address_dmem = '0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_drain_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_sb_left"}, sb.size(), 32'h0);
  endtask

  // Scoreboard: each lit interval must match the next queued colour and last ON cycles.
  logic [3:0] prev_led = '0;
  int         run_len = 0;
  logic [1:0] exp_c;
  always @(negedge clock) begin
    if (reset) begin
      prev_led = '0;
      run_len  = 0;
    end else begin
      if (led != '0 && prev_led == '0) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_colour", led, 32'h0);
        end else begin
          exp_c = sb.pop_front();
          check("sb_colour", led, 32'(4'b0001 << exp_c));
        end
        run_len = 1;
      end else if (led != '0) begin
        run_len++;
        if (led != prev_led) check("sb_led_stable", led, prev_led);
      end else if (prev_led != '0 && !sb_skip) begin
        check("sb_on_len", run_len, ON);
      end
      prev_led = led;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  led;
    logic [10:0] st;
  } vec_t;

  vec_t tbl [28];
  logic [3:0] pat;

  initial begin
    // single colour (upper data bits ignored), foreign addresses, then back-to-back 0,1,3
    tbl[0]  = '{1'b1, 12'd6, 32'hFFFF_FFFE, 4'b0000, 11'h011};
    tbl[1]  = '{1'b0, 12'd0, 32'h0, 4'b0100, 11'h003};
    tbl[2]  = '{1'b0, 12'd0, 32'h0, 4'b0100, 11'h003};
    tbl[3]  = '{1'b0, 12'd0, 32'h0, 4'b0100, 11'h003};
    tbl[4]  = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h003};
    tbl[5]  = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h003};
    tbl[6]  = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h002};
    tbl[7]  = '{1'b1, 12'd5, 32'h1, 4'b0000, 11'h002};
    tbl[8]  = '{1'b1, 12'd8, 32'h3, 4'b0000, 11'h002};
    tbl[9]  = '{1'b1, 12'd6, 32'h0, 4'b0000, 11'h011};
    tbl[10] = '{1'b1, 12'd6, 32'h1, 4'b0001, 11'h011};
    tbl[11] = '{1'b1, 12'd6, 32'h3, 4'b0001, 11'h021};
    tbl[12] = '{1'b0, 12'd0, 32'h0, 4'b0001, 11'h021};
    tbl[13] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h021};
    tbl[14] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h021};
    tbl[15] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h021};
    tbl[16] = '{1'b0, 12'd0, 32'h0, 4'b0010, 11'h011};
    tbl[17] = '{1'b0, 12'd0, 32'h0, 4'b0010, 11'h011};
    tbl[18] = '{1'b0, 12'd0, 32'h0, 4'b0010, 11'h011};
    tbl[19] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h011};
    tbl[20] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h011};
    tbl[21] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h011};
    tbl[22] = '{1'b0, 12'd0, 32'h0, 4'b1000, 11'h003};
    tbl[23] = '{1'b0, 12'd0, 32'h0, 4'b1000, 11'h003};
    tbl[24] = '{1'b0, 12'd0, 32'h0, 4'b1000, 11'h003};
    tbl[25] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h003};
    tbl[26] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h003};
    tbl[27] = '{1'b0, 12'd0, 32'h0, 4'b0000, 11'h002};

    reset = 1'b1;
    wren = 1'b0;
    address_dmem = '0;
    data = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_led", led, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_status_unselected", q_status, 32'h0);
    address_dmem = 12'd6;
    #1;
    check("status_at_data_addr", q_status, 32'h0);
    address_dmem = '0;
    chk_status("rst_status", 32'h002);
`ifdef LED_PLAYER_TONE_EN
    check("rst_tone", {31'h0, tone}, 32'h0);
`endif

    for (int i = 0; i < 28; i++) begin
      if (tbl[i].w && tbl[i].a == 12'd6) sb.push_back(tbl[i].d[1:0]);
      cyc(tbl[i].w, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d_led", i), led, tbl[i].led);
      check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].st[0]});
      chk_status($sformatf("vec%0d_status", i), {21'h0, tbl[i].st});
    end

    // overflow: first push is popped at once, then 4 accepted, 2 dropped
    push(2'd3); push(2'd1); push(2'd2); push(2'd3); push(2'd0);
    push_drop(2'd2); push_drop(2'd1);
    chk_status("ovf_set", 32'h04D);
    cmd(32'h2);
    chk_status("ovf_clear", 32'h031);
    wait_idle("ovf", 60);

    // full queue with a push on the IDLE pop cycle
    push(2'd2); push(2'd0); push(2'd1); push(2'd2); push(2'd3);
    idle(2);
    chk_status("full_pre", 32'h045);
    push(2'd1);
    chk_status("full_pop_push", 32'h045);
    wait_idle("fullpop", 60);

    // abort during ON, then wrap the pointers
    push(2'd1); push(2'd2); push(2'd3);
    sb_skip = 1'b1;
    cmd(32'h1);
    check("abort_led", led, 32'h0);
    chk_status("abort_status", 32'h002);
    sb.delete();
    idle(2);
    check("abort_led_quiet", led, 32'h0);
    chk_status("abort_status_quiet", 32'h002);
    sb_skip = 1'b0;
    push(2'd0); push(2'd1); push(2'd2); push(2'd3); push(2'd2);
    chk_status("wrap_full", 32'h045);
    wait_idle("wrap", 80);
    chk_status("wrap_end", 32'h002);

    // reset asserted for one cycle during GAP drops the queued colour
    push(2'd1); idle(1); push(2'd2); idle(2);
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    check("rstgap_led", led, 32'h0);
    check("rstgap_busy", {31'h0, busy}, 32'h0);
    chk_status("rstgap_status", 32'h002);
`ifdef LED_PLAYER_TONE_EN
    check("rstgap_tone", {31'h0, tone}, 32'h0);
`endif
    idle(3);
    check("rstgap_led_quiet", led, 32'h0);
    chk_status("rstgap_status_quiet", 32'h002);

`ifdef LED_PLAYER_TONE_EN
    // colour 1: half-period 2 cycles; colour 0: half-period 1 cycle
    push(2'd1);
    check("tone_c1_idle", {31'h0, tone}, 32'h0);
    pat = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check($sformatf("tone_c1_k%0d", k), {31'h0, tone}, {31'h0, pat[k]});
    end
    wait_idle("tone1", 20);
    push(2'd0);
    pat = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check($sformatf("tone_c0_k%0d", k), {31'h0, tone}, {31'h0, pat[k]});
    end
    wait_idle("tone0", 20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
